// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counter with optional auto-reload, expiry pulse and
//            IDLE/RUN/DONE status.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter_out,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_reload;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_reload    <= c_ZERO;
            counter_out <= c_ZERO;
            busy        <= 1'b0;
            done        <= 1'b0;
            expired     <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                counter_out <= load_value;
                r_reload    <= load_value;
                if (load_value != c_ZERO) begin
                    r_state <= RUN;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                end else begin
                    // A zero start count expires on the loading edge itself.
                    r_state <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    expired <= 1'b1;
                end
            end else if (r_state == RUN && enable) begin
                if (counter_out > c_ONE) begin
                    counter_out <= counter_out - c_ONE;
                end else begin
                    expired <= 1'b1;
                    if (auto_reload) begin
                        counter_out <= r_reload;
                    end else begin
                        counter_out <= c_ZERO;
                        r_state     <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
